// File: rtl/sa_feeder.sv
// Buffers one un-skewed operand tile and replays it to the systolic array as skewed lanes followed by the bias phase.
// Optional SA_FEEDER_DBUF_EN adds a shadow tile bank so the next tile can load while the current one plays.
module sa_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_NUM    = 8,
    parameter int COL_NUM    = 8,
    parameter int INTER_NUM  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [COL_NUM-1:0][DATA_WIDTH-1:0]    in_a,
    input  logic [ROW_NUM-1:0][DATA_WIDTH-1:0]    in_w,
    input  logic [COL_NUM-1:0][DATA_WIDTH-1:0]    in_bias,
    output logic                                  sa_iv_o,
    output logic                                  sa_mac_iv_o,
    output logic                                  sa_bias_iv_o,
    output logic [COL_NUM-1:0][DATA_WIDTH-1:0]    row_A_o,
    output logic [ROW_NUM-1:0][DATA_WIDTH-1:0]    col_W_o,
    output logic [COL_NUM-1:0][DATA_WIDTH-1:0]    bias_col_o,
    output logic                                  busy_o,
    output logic                                  done_o
);

    localparam int MAX_RC = (ROW_NUM > COL_NUM) ? ROW_NUM : COL_NUM;
    localparam int L_LEN  = INTER_NUM + MAX_RC - 1;
    localparam int BW     = $clog2(INTER_NUM) + 1;
    localparam int PW     = $clog2(L_LEN) + 1;
`ifdef SA_FEEDER_DBUF_EN
    localparam int NBANK  = 2;
`else
    localparam int NBANK  = 1;
`endif

    localparam logic [BW-1:0] LAST_BEAT = BW'(INTER_NUM - 1);
    localparam logic [PW-1:0] MAC_LAST  = PW'(L_LEN - 1);
    localparam logic [PW-1:0] BIAS_LAST = PW'(ROW_NUM - 1);
    localparam logic [PW-1:0] TAIL_LAST = PW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_MAC,
        S_GAP,
        S_BIAS,
        S_TAIL
    } state_t;

    typedef logic [COL_NUM-1:0][DATA_WIDTH-1:0] a_vec_t;
    typedef logic [ROW_NUM-1:0][DATA_WIDTH-1:0] w_vec_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [NBANK-1:0] full_q, full_d;
    logic             rd_bank_q, rd_bank_d;

    a_vec_t buf_a_q [NBANK][INTER_NUM];
    a_vec_t buf_a_d [NBANK][INTER_NUM];
    w_vec_t buf_w_q [NBANK][INTER_NUM];
    w_vec_t buf_w_d [NBANK][INTER_NUM];
    a_vec_t bias_q  [NBANK];
    a_vec_t bias_d  [NBANK];

    logic   sa_iv_q, sa_iv_d;
    logic   mac_iv_q, mac_iv_d;
    logic   bias_iv_q, bias_iv_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    a_vec_t row_a_q, row_a_d;
    w_vec_t col_w_q, col_w_d;
    a_vec_t bias_col_q, bias_col_d;

    logic loading;
    logic xfer;
    logic last_xfer;
    logic wr_bank;
`ifdef SA_FEEDER_DBUF_EN
    logic shadow_full;
`endif

    // While a tile plays, beats land in the shadow bank; otherwise they fill the bank about to play.
    always_comb begin
        loading = (state_q == S_IDLE) || (state_q == S_LOAD);
`ifdef SA_FEEDER_DBUF_EN
        shadow_full = 1'b0;
        for (int b = 0; b < NBANK; b++) begin
            if (1'(b) != rd_bank_q) shadow_full = full_q[b];
        end
        wr_bank  = loading ? rd_bank_q : ~rd_bank_q;
        in_ready = !rst && (loading || !shadow_full);
`else
        wr_bank  = 1'b0;
        in_ready = !rst && loading;
`endif
        xfer      = in_valid && in_ready;
        last_xfer = xfer && (beat_q == LAST_BEAT);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        full_d    = full_q;
        rd_bank_d = rd_bank_q;
        buf_a_d   = buf_a_q;
        buf_w_d   = buf_w_q;
        bias_d    = bias_q;
        done_d    = 1'b0;

        if (xfer) begin
            for (int b = 0; b < NBANK; b++) begin
                for (int k = 0; k < INTER_NUM; k++) begin
                    if (1'(b) == wr_bank && beat_q == BW'(k)) begin
                        buf_a_d[b][k] = in_a;
                        buf_w_d[b][k] = in_w;
                    end
                end
                if (1'(b) == wr_bank && last_xfer) begin
                    bias_d[b] = in_bias;
                    full_d[b] = 1'b1;
                end
            end
            beat_d = last_xfer ? '0 : beat_q + BW'(1);
        end

        case (state_q)
            S_IDLE, S_LOAD: begin
                if (xfer) state_d = last_xfer ? S_START : S_LOAD;
            end
            S_START: begin
                state_d = S_MAC;
                cnt_d   = '0;
            end
            S_MAC: begin
                if (cnt_q == MAC_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            S_GAP: begin
                state_d = S_BIAS;
                cnt_d   = '0;
            end
            S_BIAS: begin
                if (cnt_q == BIAS_LAST) begin
                    state_d = S_TAIL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            S_TAIL: begin
                if (cnt_q == TAIL_LAST) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    for (int b = 0; b < NBANK; b++) begin
                        if (1'(b) == rd_bank_q) full_d[b] = 1'b0;
                    end
`ifdef SA_FEEDER_DBUF_EN
                    // The shadow bank always becomes active so a partly loaded tile keeps filling it.
                    rd_bank_d = ~rd_bank_q;
                    state_d   = (shadow_full || last_xfer) ? S_START : S_IDLE;
`else
                    state_d   = S_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        sa_iv_d   = (state_d != S_IDLE) && (state_d != S_LOAD);
        busy_d    = sa_iv_d;
        mac_iv_d  = (state_d == S_MAC);
        bias_iv_d = (state_d == S_BIAS);

        row_a_d    = '0;
        col_w_d    = '0;
        bias_col_d = '0;
        // Lane j lags lane 0 by j cycles, giving the diagonal skew the array expects.
        if (state_d == S_MAC) begin
            for (int b = 0; b < NBANK; b++) begin
                for (int k = 0; k < INTER_NUM; k++) begin
                    for (int j = 0; j < COL_NUM; j++) begin
                        if (1'(b) == rd_bank_q && int'(cnt_d) - j == k) row_a_d[j] = buf_a_q[b][k][j];
                    end
                    for (int j = 0; j < ROW_NUM; j++) begin
                        if (1'(b) == rd_bank_q && int'(cnt_d) - j == k) col_w_d[j] = buf_w_q[b][k][j];
                    end
                end
            end
        end
        if (state_d == S_BIAS) begin
            for (int b = 0; b < NBANK; b++) begin
                if (1'(b) == rd_bank_q) bias_col_d = bias_q[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            beat_q     <= '0;
            full_q     <= '0;
            rd_bank_q  <= 1'b0;
            sa_iv_q    <= 1'b0;
            mac_iv_q   <= 1'b0;
            bias_iv_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            row_a_q    <= '0;
            col_w_q    <= '0;
            bias_col_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            full_q     <= full_d;
            rd_bank_q  <= rd_bank_d;
            sa_iv_q    <= sa_iv_d;
            mac_iv_q   <= mac_iv_d;
            bias_iv_q  <= bias_iv_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            row_a_q    <= row_a_d;
            col_w_q    <= col_w_d;
            bias_col_q <= bias_col_d;
        end
        buf_a_q <= buf_a_d;
        buf_w_q <= buf_w_d;
        bias_q  <= bias_d;
    end

    assign sa_iv_o      = sa_iv_q;
    assign sa_mac_iv_o  = mac_iv_q;
    assign sa_bias_iv_o = bias_iv_q;
    assign row_A_o      = row_a_q;
    assign col_W_o      = col_w_q;
    assign bias_col_o   = bias_col_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_sa_feeder.sv
// Directed bench for sa_feeder: default 8x8x8 instance plus a 4x4, INTER_NUM=1 boundary instance.
module tb_sa_feeder;

    localparam int DW  = 8;
    localparam int RN  = 8;
    localparam int CN  = 8;
    localparam int IN  = 8;
    localparam int L   = IN + ((RN > CN) ? RN : CN) - 1;
    localparam int SEQ = L + RN + 5;

    typedef logic [CN-1:0][DW-1:0] a_vec_t;
    typedef logic [RN-1:0][DW-1:0] w_vec_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   in_valid = 1'b0;
    logic   in_ready;
    a_vec_t in_a = '0;
    w_vec_t in_w = '0;
    a_vec_t in_bias = '0;
    logic   sa_iv_o, sa_mac_iv_o, sa_bias_iv_o, busy_o, done_o;
    a_vec_t row_A_o, bias_col_o;
    w_vec_t col_W_o;

    logic             s_in_valid = 1'b0;
    logic             s_in_ready;
    logic [3:0][7:0]  s_in_a = '0, s_in_w = '0, s_in_bias = '0;
    logic             s_sa_iv, s_mac_iv, s_bias_iv, s_busy, s_done;
    logic [3:0][7:0]  s_row, s_col, s_bcol;

    int checks = 0;
    int errors = 0;

    logic [4:0] cap_ctrl [SEQ];
    a_vec_t     cap_row  [SEQ];
    w_vec_t     cap_col  [SEQ];
    a_vec_t     cap_bias [SEQ];
    logic       cap_rdy  [SEQ];

    always #5 clk = ~clk;

    sa_feeder #(.DATA_WIDTH(DW), .ROW_NUM(RN), .COL_NUM(CN), .INTER_NUM(IN)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_w(in_w), .in_bias(in_bias),
        .sa_iv_o(sa_iv_o), .sa_mac_iv_o(sa_mac_iv_o), .sa_bias_iv_o(sa_bias_iv_o),
        .row_A_o(row_A_o), .col_W_o(col_W_o), .bias_col_o(bias_col_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    sa_feeder #(.DATA_WIDTH(8), .ROW_NUM(4), .COL_NUM(4), .INTER_NUM(1)) u_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_w(s_in_w), .in_bias(s_in_bias),
        .sa_iv_o(s_sa_iv), .sa_mac_iv_o(s_mac_iv), .sa_bias_iv_o(s_bias_iv),
        .row_A_o(s_row), .col_W_o(s_col), .bias_col_o(s_bcol),
        .busy_o(s_busy), .done_o(s_done)
    );

    // Tile contents by kind: 0 is the reference tile, 1 and 2 vary per beat so slot order is visible.
    function automatic logic [7:0] gen_a(int kind, int k, int j);
        case (kind)
            0:       return 8'(j + 1);
            1:       return 8'(16 * k + j + 1);
            default: return 8'(8'hA0 + 8 * k + j);
        endcase
    endfunction

    function automatic logic [7:0] gen_w(int kind, int k, int j);
        case (kind)
            0:       return 8'h20;
            1:       return 8'(8'h80 + 8 * k + j);
            default: return 8'(8'h10 + 9 * k + j);
        endcase
    endfunction

    function automatic logic [7:0] gen_b(int kind, int j);
        case (kind)
            0:       return 8'(4 - j);
            1:       return 8'(8'h40 + j);
            default: return 8'(8'hF0 - j);
        endcase
    endfunction

    // Control bits {sa_iv, mac_iv, bias_iv, busy, done} for cycle c after the last beat.
    function automatic logic [4:0] exp_ctrl(int c);
        if (c == 0)                        return 5'b10010;
        if (c >= 1 && c <= L)              return 5'b11010;
        if (c == L + 1)                    return 5'b10010;
        if (c >= L + 2 && c <= L + 1 + RN) return 5'b10110;
        if (c >= L + 2 + RN && c <= L + 3 + RN) return 5'b10010;
        if (c == L + 4 + RN)               return 5'b00001;
        return 5'b00000;
    endfunction

    function automatic a_vec_t exp_row(int kind, int c);
        a_vec_t v = '0;
        if (c >= 1 && c <= L)
            for (int j = 0; j < CN; j++)
                if (c - 1 - j >= 0 && c - 1 - j < IN) v[j] = gen_a(kind, c - 1 - j, j);
        return v;
    endfunction

    function automatic w_vec_t exp_col(int kind, int c);
        w_vec_t v = '0;
        if (c >= 1 && c <= L)
            for (int j = 0; j < RN; j++)
                if (c - 1 - j >= 0 && c - 1 - j < IN) v[j] = gen_w(kind, c - 1 - j, j);
        return v;
    endfunction

    function automatic a_vec_t exp_bias(int kind, int c);
        a_vec_t v = '0;
        if (c >= L + 2 && c <= L + 1 + RN)
            for (int j = 0; j < CN; j++) v[j] = gen_b(kind, j);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(int kind, int k);
        for (int j = 0; j < CN; j++) in_a[j] = gen_a(kind, k, j);
        for (int j = 0; j < RN; j++) in_w[j] = gen_w(kind, k, j);
        for (int j = 0; j < CN; j++) in_bias[j] = (k == IN - 1) ? gen_b(kind, j) : 8'hEE;
        in_valid = 1'b1;
    endtask

    // Leaves the bench at cycle 0 (first cycle after the last-beat edge).
    task automatic load_tile(int kind, bit stall);
        for (int k = 0; k < IN; k++) begin
            if (stall && k > 0) begin
                in_valid = 1'b0;
                in_a = '1;
                in_w = '1;
                step();
                step();
            end
            drive_beat(kind, k);
            for (int n = 0; n < 200 && !in_ready; n++) step();
            if (!in_ready) begin
                checks++;
                errors++;
                $display("[TB] FAIL load_wait beat=%0d in_ready got 0 want 1", k);
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic capture_seq();
        for (int c = 0; c < SEQ; c++) begin
            cap_ctrl[c] = {sa_iv_o, sa_mac_iv_o, sa_bias_iv_o, busy_o, done_o};
            cap_row[c]  = row_A_o;
            cap_col[c]  = col_W_o;
            cap_bias[c] = bias_col_o;
            cap_rdy[c]  = in_ready;
            if (c < SEQ - 1) step();
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        step();
        step();
        checks++;
        if ({sa_iv_o, sa_mac_iv_o, sa_bias_iv_o, busy_o, done_o, in_ready} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b want 000000", {sa_iv_o, sa_mac_iv_o, sa_bias_iv_o, busy_o, done_o, in_ready});
        end
        checks++;
        if ({row_A_o, col_W_o, bias_col_o} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_lanes got %h want 0", {row_A_o, col_W_o, bias_col_o});
        end
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL idle_ready got %b%b want 11", in_ready, s_in_ready);
        end
    endtask

    task automatic test_single();
        load_tile(0, 1'b0);
        capture_seq();
        for (int c = 0; c < SEQ; c++) begin
            checks++;
            if (cap_ctrl[c] !== exp_ctrl(c)) begin errors++; $display("[TB] FAIL single_ctrl c=%0d got %b want %b", c, cap_ctrl[c], exp_ctrl(c)); end
            checks++;
            if (cap_row[c] !== exp_row(0, c)) begin errors++; $display("[TB] FAIL single_row c=%0d got %h want %h", c, cap_row[c], exp_row(0, c)); end
            checks++;
            if (cap_col[c] !== exp_col(0, c)) begin errors++; $display("[TB] FAIL single_col c=%0d got %h want %h", c, cap_col[c], exp_col(0, c)); end
            checks++;
            if (cap_bias[c] !== exp_bias(0, c)) begin errors++; $display("[TB] FAIL single_bias c=%0d got %h want %h", c, cap_bias[c], exp_bias(0, c)); end
        end
        // Hand-derived spot values: MAC cycle t is capture index t+1.
        for (int t = 0; t < 15; t++) begin
            checks++;
            if (cap_row[t + 1][3] !== ((t >= 3 && t <= 10) ? 8'd4 : 8'd0)) begin errors++; $display("[TB] FAIL row3 t=%0d got %h", t, cap_row[t + 1][3]); end
            checks++;
            if (cap_col[t + 1][7] !== ((t >= 7) ? 8'h20 : 8'h00)) begin errors++; $display("[TB] FAIL col7 t=%0d got %h", t, cap_col[t + 1][7]); end
        end
        checks++;
        if (cap_row[16] !== '0 || cap_col[16] !== '0) begin errors++; $display("[TB] FAIL lanes_t15 got %h %h want 0", cap_row[16], cap_col[16]); end
        checks++;
        if (cap_bias[17] !== 64'hFDFEFF0001020304) begin errors++; $display("[TB] FAIL bias_vec got %h want fdfeff0001020304", cap_bias[17]); end
        checks++;
        if (cap_ctrl[27][0] !== 1'b1 || cap_ctrl[26][0] !== 1'b0) begin errors++; $display("[TB] FAIL done_latency got %b%b want 01", cap_ctrl[26][0], cap_ctrl[27][0]); end
        step();
        checks++;
        if ({done_o, sa_iv_o, busy_o, in_ready} !== 4'b0001) begin errors++; $display("[TB] FAIL done_pulse got %b want 0001", {done_o, sa_iv_o, busy_o, in_ready}); end
    endtask

    task automatic test_stalls();
        load_tile(0, 1'b1);
        capture_seq();
        for (int c = 0; c < SEQ; c++) begin
            checks++;
            if (cap_ctrl[c] !== exp_ctrl(c)) begin errors++; $display("[TB] FAIL stall_ctrl c=%0d got %b want %b", c, cap_ctrl[c], exp_ctrl(c)); end
            checks++;
            if (cap_row[c] !== exp_row(0, c) || cap_col[c] !== exp_col(0, c) || cap_bias[c] !== exp_bias(0, c)) begin
                errors++;
                $display("[TB] FAIL stall_lanes c=%0d got %h %h %h", c, cap_row[c], cap_col[c], cap_bias[c]);
            end
        end
        step();
    endtask

`ifndef SA_FEEDER_DBUF_EN
    task automatic test_backpressure();
        load_tile(0, 1'b0);
        drive_beat(1, 0);
        capture_seq();
        for (int c = 0; c < SEQ; c++) begin
            checks++;
            if (cap_rdy[c] !== (c == SEQ - 1)) begin errors++; $display("[TB] FAIL bp_ready c=%0d got %b want %b", c, cap_rdy[c], c == SEQ - 1); end
            checks++;
            if (cap_ctrl[c] !== exp_ctrl(c) || cap_row[c] !== exp_row(0, c) || cap_col[c] !== exp_col(0, c) || cap_bias[c] !== exp_bias(0, c)) begin
                errors++;
                $display("[TB] FAIL bp_first c=%0d got %b %h %h %h", c, cap_ctrl[c], cap_row[c], cap_col[c], cap_bias[c]);
            end
        end
        load_tile(1, 1'b0);
        capture_seq();
        for (int c = 0; c < SEQ; c++) begin
            checks++;
            if (cap_ctrl[c] !== exp_ctrl(c) || cap_row[c] !== exp_row(1, c) || cap_col[c] !== exp_col(1, c) || cap_bias[c] !== exp_bias(1, c)) begin
                errors++;
                $display("[TB] FAIL bp_second c=%0d got %b %h %h %h", c, cap_ctrl[c], cap_row[c], cap_col[c], cap_bias[c]);
            end
        end
        step();
    endtask
`else
    task automatic test_back_to_back();
        load_tile(0, 1'b0);
        for (int c = 0; c < SEQ; c++) begin
            cap_ctrl[c] = {sa_iv_o, sa_mac_iv_o, sa_bias_iv_o, busy_o, done_o};
            cap_row[c]  = row_A_o;
            cap_col[c]  = col_W_o;
            cap_bias[c] = bias_col_o;
            if (c >= 1 && c <= IN) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL dbuf_ready c=%0d got 0 want 1", c); end
                drive_beat(1, c - 1);
            end else if (c == IN + 1) begin
                in_valid = 1'b0;
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL dbuf_full got 1 want 0"); end
            end
            if (c < SEQ - 1) step();
        end
        for (int c = 0; c < SEQ; c++) begin
            checks++;
            if (cap_ctrl[c] !== ((c == SEQ - 1) ? 5'b10011 : exp_ctrl(c)) || cap_row[c] !== exp_row(0, c) ||
                cap_col[c] !== exp_col(0, c) || cap_bias[c] !== exp_bias(0, c)) begin
                errors++;
                $display("[TB] FAIL dbuf_first c=%0d got %b %h %h %h", c, cap_ctrl[c], cap_row[c], cap_col[c], cap_bias[c]);
            end
        end
        capture_seq();
        for (int c = 0; c < SEQ; c++) begin
            checks++;
            if (cap_ctrl[c] !== ((c == 0) ? 5'b10011 : exp_ctrl(c)) || cap_row[c] !== exp_row(1, c) ||
                cap_col[c] !== exp_col(1, c) || cap_bias[c] !== exp_bias(1, c)) begin
                errors++;
                $display("[TB] FAIL dbuf_second c=%0d got %b %h %h %h", c, cap_ctrl[c], cap_row[c], cap_col[c], cap_bias[c]);
            end
        end
        step();
    endtask
`endif

    task automatic test_reset_mid();
        load_tile(2, 1'b0);
        for (int c = 0; c < 6; c++) step();
        checks++;
        if (sa_mac_iv_o !== 1'b1 || row_A_o[0] !== gen_a(2, 5, 0)) begin errors++; $display("[TB] FAIL mid_mac got %b %h want 1 %h", sa_mac_iv_o, row_A_o[0], gen_a(2, 5, 0)); end
        rst = 1'b1;
        step();
        checks++;
        if ({sa_iv_o, sa_mac_iv_o, sa_bias_iv_o, busy_o, done_o, in_ready} !== 6'b0 || {row_A_o, col_W_o, bias_col_o} !== '0) begin
            errors++;
            $display("[TB] FAIL mid_abort got %b %h", {sa_iv_o, sa_mac_iv_o, sa_bias_iv_o, busy_o, done_o, in_ready}, {row_A_o, col_W_o});
        end
        rst = 1'b0;
        step();
        checks++;
        if ({sa_iv_o, busy_o, done_o, in_ready} !== 4'b0001) begin errors++; $display("[TB] FAIL mid_idle got %b want 0001", {sa_iv_o, busy_o, done_o, in_ready}); end
        load_tile(1, 1'b1);
        capture_seq();
        for (int c = 0; c < SEQ; c++) begin
            checks++;
            if (cap_ctrl[c] !== exp_ctrl(c) || cap_row[c] !== exp_row(1, c) || cap_col[c] !== exp_col(1, c) || cap_bias[c] !== exp_bias(1, c)) begin
                errors++;
                $display("[TB] FAIL mid_recover c=%0d got %b %h %h %h", c, cap_ctrl[c], cap_row[c], cap_col[c], cap_bias[c]);
            end
        end
        step();
    endtask

    task automatic test_boundary();
        logic [3:0][7:0] ea, ew, eb;
        logic [4:0]      ec;
        for (int j = 0; j < 4; j++) begin
            s_in_a[j]    = 8'(17 * (j + 1));
            s_in_w[j]    = 8'(8'h50 + j);
            s_in_bias[j] = 8'(8'hC0 + j);
        end
        s_in_valid = 1'b1;
        checks++;
        if (s_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL small_ready got 0 want 1"); end
        step();
        s_in_valid = 1'b0;
        // L = 4 here: START, MAC 1..4, GAP 5, BIAS 6..9, TAIL 10..11, done at 12.
        for (int c = 0; c < 14; c++) begin
            ec = {c <= 11, c >= 1 && c <= 4, c >= 6 && c <= 9, c <= 11, c == 12};
            for (int j = 0; j < 4; j++) begin
                ea[j] = (c - 1 == j) ? s_in_a[j] : 8'h00;
                ew[j] = (c - 1 == j) ? s_in_w[j] : 8'h00;
                eb[j] = (c >= 6 && c <= 9) ? s_in_bias[j] : 8'h00;
            end
            checks++;
            if ({s_sa_iv, s_mac_iv, s_bias_iv, s_busy, s_done} !== ec) begin
                errors++;
                $display("[TB] FAIL small_ctrl c=%0d got %b want %b", c, {s_sa_iv, s_mac_iv, s_bias_iv, s_busy, s_done}, ec);
            end
            checks++;
            if (s_row !== ea || s_col !== ew || s_bcol !== eb) begin
                errors++;
                $display("[TB] FAIL small_lanes c=%0d got %h %h %h want %h %h %h", c, s_row, s_col, s_bcol, ea, ew, eb);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stalls();
`ifndef SA_FEEDER_DBUF_EN
        test_backpressure();
`else
        test_back_to_back();
`endif
        test_reset_mid();
        test_boundary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
